// File: rtl/rop_types.sv
// ROP state types: blend/logic-op encodings, the extended CSR record, field addresses,
// reset defaults and the field-write helper shared by the context slots.
package rop_types;

    localparam int unsigned ROP_BLEND_FUNC_BITS = 5;
    localparam int unsigned ROP_LOGIC_OP_BITS   = 4;
    localparam int unsigned ROP_BLEND_MODE_BITS = 3;

    typedef enum logic [ROP_BLEND_FUNC_BITS-1:0] {
        ROP_BLEND_ZERO                  = 5'd0,
        ROP_BLEND_ONE                   = 5'd1,
        ROP_BLEND_SRC_COLOR             = 5'd2,
        ROP_BLEND_ONE_MINUS_SRC_COLOR   = 5'd3,
        ROP_BLEND_DST_COLOR             = 5'd4,
        ROP_BLEND_ONE_MINUS_DST_COLOR   = 5'd5,
        ROP_BLEND_SRC_ALPHA             = 5'd6,
        ROP_BLEND_ONE_MINUS_SRC_ALPHA   = 5'd7,
        ROP_BLEND_DST_ALPHA             = 5'd8,
        ROP_BLEND_ONE_MINUS_DST_ALPHA   = 5'd9,
        ROP_BLEND_CONST_COLOR           = 5'd10,
        ROP_BLEND_ONE_MINUS_CONST_COLOR = 5'd11,
        ROP_BLEND_CONST_ALPHA           = 5'd12,
        ROP_BLEND_ONE_MINUS_CONST_ALPHA = 5'd13,
        ROP_BLEND_ALPHA_SAT             = 5'd14
    } rop_blend_func_e;

    typedef enum logic [ROP_LOGIC_OP_BITS-1:0] {
        ROP_LOGIC_CLEAR         = 4'd0,
        ROP_LOGIC_AND           = 4'd1,
        ROP_LOGIC_AND_REVERSE   = 4'd2,
        ROP_LOGIC_COPY          = 4'd3,
        ROP_LOGIC_AND_INVERTED  = 4'd4,
        ROP_LOGIC_NOOP          = 4'd5,
        ROP_LOGIC_XOR           = 4'd6,
        ROP_LOGIC_OR            = 4'd7,
        ROP_LOGIC_NOR           = 4'd8,
        ROP_LOGIC_EQUIV         = 4'd9,
        ROP_LOGIC_INVERT        = 4'd10,
        ROP_LOGIC_OR_REVERSE    = 4'd11,
        ROP_LOGIC_COPY_INVERTED = 4'd12,
        ROP_LOGIC_OR_INVERTED   = 4'd13,
        ROP_LOGIC_NAND          = 4'd14,
        ROP_LOGIC_SET           = 4'd15
    } rop_logic_op_e;

    typedef enum logic [ROP_BLEND_MODE_BITS-1:0] {
        ROP_MODE_ADD      = 3'd0,
        ROP_MODE_SUB      = 3'd1,
        ROP_MODE_REV_SUB  = 3'd2,
        ROP_MODE_MIN      = 3'd3,
        ROP_MODE_MAX      = 3'd4,
        ROP_MODE_LOGIC_OP = 3'd5
    } rop_blend_mode_e;

    // Legacy flat single-context record.
    typedef struct packed {
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_src_rgb;
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_dst_rgb;
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_src_a;
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_dst_a;
        logic [31:0]                    blend_const;
        logic [ROP_LOGIC_OP_BITS-1:0]   logic_op;
    } rop_csrs_t;

    typedef struct packed {
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_src_rgb;
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_dst_rgb;
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_src_a;
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_dst_a;
        logic [31:0]                    blend_const;
        logic [ROP_LOGIC_OP_BITS-1:0]   logic_op;
        logic [ROP_BLEND_MODE_BITS-1:0] blend_mode_rgb;
        logic [ROP_BLEND_MODE_BITS-1:0] blend_mode_a;
    } rop_csrs_ext_t;

    localparam logic [2:0] ROP_ADDR_BLEND_SRC_RGB  = 3'd0;
    localparam logic [2:0] ROP_ADDR_BLEND_DST_RGB  = 3'd1;
    localparam logic [2:0] ROP_ADDR_BLEND_SRC_A    = 3'd2;
    localparam logic [2:0] ROP_ADDR_BLEND_DST_A    = 3'd3;
    localparam logic [2:0] ROP_ADDR_BLEND_CONST    = 3'd4;
    localparam logic [2:0] ROP_ADDR_LOGIC_OP       = 3'd5;
    localparam logic [2:0] ROP_ADDR_BLEND_MODE_RGB = 3'd6;
    localparam logic [2:0] ROP_ADDR_BLEND_MODE_A   = 3'd7;

    localparam rop_csrs_ext_t ROP_CSRS_EXT_DEFAULT = '{
        blend_src_rgb:  ROP_BLEND_ONE,
        blend_dst_rgb:  ROP_BLEND_ZERO,
        blend_src_a:    ROP_BLEND_ONE,
        blend_dst_a:    ROP_BLEND_ZERO,
        blend_const:    32'h0,
        logic_op:       ROP_LOGIC_COPY,
        blend_mode_rgb: ROP_MODE_ADD,
        blend_mode_a:   ROP_MODE_ADD
    };

    // Returns cur with the addressed field replaced by the low bits of data.
    function automatic rop_csrs_ext_t rop_csr_write(input rop_csrs_ext_t cur,
                                                    input logic [2:0]    addr,
                                                    input logic [31:0]   data);
        rop_csrs_ext_t nxt;
        nxt = cur;
        unique case (addr)
            ROP_ADDR_BLEND_SRC_RGB:  nxt.blend_src_rgb  = data[ROP_BLEND_FUNC_BITS-1:0];
            ROP_ADDR_BLEND_DST_RGB:  nxt.blend_dst_rgb  = data[ROP_BLEND_FUNC_BITS-1:0];
            ROP_ADDR_BLEND_SRC_A:    nxt.blend_src_a    = data[ROP_BLEND_FUNC_BITS-1:0];
            ROP_ADDR_BLEND_DST_A:    nxt.blend_dst_a    = data[ROP_BLEND_FUNC_BITS-1:0];
            ROP_ADDR_BLEND_CONST:    nxt.blend_const    = data;
            ROP_ADDR_LOGIC_OP:       nxt.logic_op       = data[ROP_LOGIC_OP_BITS-1:0];
            ROP_ADDR_BLEND_MODE_RGB: nxt.blend_mode_rgb = data[ROP_BLEND_MODE_BITS-1:0];
            ROP_ADDR_BLEND_MODE_A:   nxt.blend_mode_a   = data[ROP_BLEND_MODE_BITS-1:0];
            default:                 nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rop_ctx_slot.sv
// One ROP state context: shadow/active copies, in-flight fragment counter and the
// commit FSM that copies shadow to active once the context has drained.
module rop_ctx_slot
    import rop_types::*;
#(
    parameter int unsigned INFLIGHT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [2:0]    wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          commit_en,
    input  logic          inc,
    input  logic          dec,
    output logic          pending,
    output logic          done,
    output rop_csrs_ext_t active
);

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PENDING = 1'b1;

    localparam logic [INFLIGHT_W-1:0] CNT_MAX = '1;

    logic                  state_q, state_d;
    logic [INFLIGHT_W-1:0] cnt_q, cnt_d;
    rop_csrs_ext_t         shadow_q, shadow_d;
    rop_csrs_ext_t         active_q, active_d;
    logic                  done_q, done_d;

    logic wr_ok, commit_ok, copy, inc_ok, dec_ok;

    always_comb begin
        wr_ok     = wr_en && (state_q == ST_IDLE);
        commit_ok = commit_en && (state_q == ST_IDLE);
        // Copy decision uses the registered count, so a retirement in this same cycle
        // only releases the commit on the following edge.
        copy      = (state_q == ST_PENDING) && (cnt_q == '0);
        inc_ok    = inc && !dec && (state_q == ST_IDLE) && (cnt_q != CNT_MAX);
        dec_ok    = dec && !inc && (cnt_q != '0);

        state_d = state_q;
        if (state_q == ST_IDLE) begin
            if (commit_ok) begin
                state_d = ST_PENDING;
            end
        end else if (copy) begin
            state_d = ST_IDLE;
        end

        cnt_d = cnt_q;
        if (inc_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_ok) begin
            cnt_d = cnt_q - 1'b1;
        end

        shadow_d = wr_ok ? rop_csr_write(shadow_q, wr_addr, wr_data) : shadow_q;
        active_d = copy ? shadow_q : active_q;
        done_d   = copy;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= ROP_CSRS_EXT_DEFAULT;
            active_q <= ROP_CSRS_EXT_DEFAULT;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            done_q   <= done_d;
            assert (!(inc && (cnt_q == CNT_MAX)));
            assert (!(dec && (cnt_q == '0)));
            assert (!(inc && (state_q == ST_PENDING)));
        end
    end

    assign pending = (state_q == ST_PENDING);
    assign done    = done_q;
    assign active  = active_q;

endmodule

// File: rtl/rop_csr_bank.sv
// Multi-context double-buffered ROP state bank: routes CSR writes, commits and fragment
// traffic to per-context slots and muxes the active state selected by rd_ctx.
module rop_csr_bank
    import rop_types::*;
#(
    parameter  int unsigned NUM_CTX    = 4,
    parameter  int unsigned INFLIGHT_W = 8,
    localparam int unsigned CTX_W      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               csr_wr_valid,
    input  logic [CTX_W-1:0]   csr_wr_ctx,
    input  logic [2:0]         csr_wr_addr,
    input  logic [31:0]        csr_wr_data,
    output logic               csr_wr_ready,
    input  logic               commit_valid,
    input  logic [CTX_W-1:0]   commit_ctx,
    output logic               commit_ready,
    output logic [NUM_CTX-1:0] commit_done,
    output logic [NUM_CTX-1:0] ctx_stall,
    input  logic               req_fire,
    input  logic [CTX_W-1:0]   req_ctx,
    input  logic               rsp_fire,
    input  logic [CTX_W-1:0]   rsp_ctx,
    input  logic [CTX_W-1:0]   rd_ctx,
    output rop_csrs_ext_t      rd_csrs
);

    rop_csrs_ext_t active [NUM_CTX];

    // Out-of-range context indices see an idle context and the default state.
    always_comb begin
        csr_wr_ready = 1'b1;
        commit_ready = 1'b1;
        rd_csrs      = ROP_CSRS_EXT_DEFAULT;
        for (int i = 0; i < NUM_CTX; i++) begin
            if ((csr_wr_ctx == CTX_W'(i)) && ctx_stall[i]) begin
                csr_wr_ready = 1'b0;
            end
            if ((commit_ctx == CTX_W'(i)) && ctx_stall[i]) begin
                commit_ready = 1'b0;
            end
            if (rd_ctx == CTX_W'(i)) begin
                rd_csrs = active[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CTX; g++) begin : g_slot
        rop_ctx_slot #(
            .INFLIGHT_W(INFLIGHT_W)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (csr_wr_valid && csr_wr_ready && (csr_wr_ctx == CTX_W'(g))),
            .wr_addr  (csr_wr_addr),
            .wr_data  (csr_wr_data),
            .commit_en(commit_valid && commit_ready && (commit_ctx == CTX_W'(g))),
            .inc      (req_fire && (req_ctx == CTX_W'(g))),
            .dec      (rsp_fire && (rsp_ctx == CTX_W'(g))),
            .pending  (ctx_stall[g]),
            .done     (commit_done[g]),
            .active   (active[g])
        );
    end

endmodule

// File: tb/tb_rop_csr_bank.sv
// Directed bench for rop_csr_bank: a field-table model of every context is checked
// against the DUT on each falling edge, plus hand-computed literal expectations.
module tb_rop_csr_bank;
    import rop_types::*;

    localparam int NCTX    = 4;
    localparam int CNT_MAX = 255;
    localparam int unsigned FW  [8] = '{5, 5, 5, 5, 32, 4, 3, 3};
    localparam int unsigned DEF [8] = '{1, 0, 1, 0, 0, 3, 0, 0};

    logic          clk;
    logic          reset;
    logic          csr_wr_valid;
    logic [1:0]    csr_wr_ctx;
    logic [2:0]    csr_wr_addr;
    logic [31:0]   csr_wr_data;
    logic          csr_wr_ready;
    logic          commit_valid;
    logic [1:0]    commit_ctx;
    logic          commit_ready;
    logic [3:0]    commit_done;
    logic [3:0]    ctx_stall;
    logic          req_fire;
    logic [1:0]    req_ctx;
    logic          rsp_fire;
    logic [1:0]    rsp_ctx;
    logic [1:0]    rd_ctx;
    rop_csrs_ext_t rd_csrs;

    rop_csr_bank #(
        .NUM_CTX   (NCTX),
        .INFLIGHT_W(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .csr_wr_valid(csr_wr_valid),
        .csr_wr_ctx  (csr_wr_ctx),
        .csr_wr_addr (csr_wr_addr),
        .csr_wr_data (csr_wr_data),
        .csr_wr_ready(csr_wr_ready),
        .commit_valid(commit_valid),
        .commit_ctx  (commit_ctx),
        .commit_ready(commit_ready),
        .commit_done (commit_done),
        .ctx_stall   (ctx_stall),
        .req_fire    (req_fire),
        .req_ctx     (req_ctx),
        .rsp_fire    (rsp_fire),
        .rsp_ctx     (rsp_ctx),
        .rd_ctx      (rd_ctx),
        .rd_csrs     (rd_csrs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fld(input rop_csrs_ext_t s, input int k);
        case (k)
            0:       return 32'(s.blend_src_rgb);
            1:       return 32'(s.blend_dst_rgb);
            2:       return 32'(s.blend_src_a);
            3:       return 32'(s.blend_dst_a);
            4:       return s.blend_const;
            5:       return 32'(s.logic_op);
            6:       return 32'(s.blend_mode_rgb);
            default: return 32'(s.blend_mode_a);
        endcase
    endfunction

    function automatic int unsigned msk(input logic [31:0] d, input int unsigned w);
        if (w >= 32) return d;
        return d & ((32'd1 << w) - 32'd1);
    endfunction

    // Model: each context is a table of 8 fields (shadow and active), a fragment count,
    // a pending-commit flag and the expected commit_done pulse.
    int unsigned m_sh [NCTX][8];
    int unsigned m_ac [NCTX][8];
    int          m_cnt [NCTX];
    bit          m_pend [NCTX];
    bit          m_done [NCTX];
    bit          p_old [NCTX];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCTX; c++) begin
                for (int f = 0; f < 8; f++) begin
                    m_sh[c][f] = DEF[f];
                    m_ac[c][f] = DEF[f];
                end
                m_cnt[c]  = 0;
                m_pend[c] = 1'b0;
                m_done[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < NCTX; c++) p_old[c] = m_pend[c];
            for (int c = 0; c < NCTX; c++) begin
                m_done[c] = 1'b0;
                if (p_old[c] && m_cnt[c] == 0) begin
                    for (int f = 0; f < 8; f++) m_ac[c][f] = m_sh[c][f];
                    m_pend[c] = 1'b0;
                    m_done[c] = 1'b1;
                end
            end
            if (csr_wr_valid && !p_old[csr_wr_ctx])
                m_sh[csr_wr_ctx][csr_wr_addr] = msk(csr_wr_data, FW[csr_wr_addr]);
            if (commit_valid && !p_old[commit_ctx])
                m_pend[commit_ctx] = 1'b1;
            if (!(req_fire && rsp_fire && req_ctx == rsp_ctx)) begin
                if (req_fire && !p_old[req_ctx] && m_cnt[req_ctx] < CNT_MAX)
                    m_cnt[req_ctx] = m_cnt[req_ctx] + 1;
                if (rsp_fire && m_cnt[rsp_ctx] > 0)
                    m_cnt[rsp_ctx] = m_cnt[rsp_ctx] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en && !reset) begin
            for (int k = 0; k < 8; k++)
                chk($sformatf("rd_csrs ctx%0d field%0d", rd_ctx, k), 64'(fld(rd_csrs, k)),
                    64'(m_ac[rd_ctx][k]));
            for (int c = 0; c < NCTX; c++) begin
                chk($sformatf("ctx_stall[%0d]", c), 64'(ctx_stall[c]), 64'(m_pend[c]));
                chk($sformatf("commit_done[%0d]", c), 64'(commit_done[c]), 64'(m_done[c]));
            end
            chk("csr_wr_ready", 64'(csr_wr_ready), 64'(!m_pend[csr_wr_ctx]));
            chk("commit_ready", 64'(commit_ready), 64'(!m_pend[commit_ctx]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        csr_wr_valid = 1'b0;
        csr_wr_ctx   = '0;
        csr_wr_addr  = '0;
        csr_wr_data  = '0;
        commit_valid = 1'b0;
        commit_ctx   = '0;
        req_fire     = 1'b0;
        req_ctx      = '0;
        rsp_fire     = 1'b0;
        rsp_ctx      = '0;
        rd_ctx       = '0;
        tick(2);
        reset    = 1'b0;
        check_en = 1'b1;

        // Reset defaults on every context.
        for (int c = 0; c < NCTX; c++) begin
            rd_ctx = 2'(c);
            #1;
            chk("rst src_rgb", 64'(rd_csrs.blend_src_rgb), 64'd1);
            chk("rst dst_rgb", 64'(rd_csrs.blend_dst_rgb), 64'd0);
            chk("rst src_a", 64'(rd_csrs.blend_src_a), 64'd1);
            chk("rst dst_a", 64'(rd_csrs.blend_dst_a), 64'd0);
            chk("rst const", 64'(rd_csrs.blend_const), 64'd0);
            chk("rst logic_op", 64'(rd_csrs.logic_op), 64'd3);
            chk("rst modes", 64'({rd_csrs.blend_mode_rgb, rd_csrs.blend_mode_a}), 64'd0);
        end
        chk("rst stall", 64'(ctx_stall), 64'd0);
        chk("rst ready", 64'({csr_wr_ready, commit_ready}), 64'd3);
        tick(1);

        // Shadow write then commit on an idle, empty context.
        csr_wr_valid = 1'b1; csr_wr_ctx = 2'd1; csr_wr_addr = 3'd4; csr_wr_data = 32'hDEADBEEF;
        tick(1);
        csr_wr_valid = 1'b0;
        rd_ctx = 2'd1;
        #1 chk("ctx1 const before commit", 64'(rd_csrs.blend_const), 64'd0);
        commit_valid = 1'b1; commit_ctx = 2'd1;
        tick(1);
        commit_valid = 1'b0;
        chk("ctx1 done not yet", 64'(commit_done), 64'd0);
        chk("ctx1 stall", 64'(ctx_stall), 64'b0010);
        tick(1);
        chk("ctx1 done pulse", 64'(commit_done), 64'b0010);
        chk("ctx1 const after", 64'(rd_csrs.blend_const), 64'hDEADBEEF);
        tick(1);
        chk("ctx1 done cleared", 64'(commit_done), 64'd0);

        // Commit waits for three in-flight fragments; write held while pending.
        req_fire = 1'b1; req_ctx = 2'd2;
        tick(3);
        req_fire = 1'b0;
        commit_valid = 1'b1; commit_ctx = 2'd2;
        tick(1);
        commit_valid = 1'b0;
        csr_wr_valid = 1'b1; csr_wr_ctx = 2'd2; csr_wr_addr = 3'd5; csr_wr_data = 32'h6;
        #1 chk("ctx2 wr held", 64'(csr_wr_ready), 64'd0);
        chk("ctx2 stall", 64'(ctx_stall[2]), 64'd1);
        rsp_fire = 1'b1; rsp_ctx = 2'd2;
        tick(3);
        rsp_fire = 1'b0;
        chk("ctx2 stall until copy", 64'(ctx_stall[2]), 64'd1);
        tick(1);
        chk("ctx2 done", 64'(commit_done), 64'b0100);
        chk("ctx2 stall clear", 64'(ctx_stall[2]), 64'd0);
        chk("ctx2 wr ready", 64'(csr_wr_ready), 64'd1);
        tick(1);
        csr_wr_valid = 1'b0;
        rd_ctx = 2'd2;
        #1 chk("ctx2 logic_op old", 64'(rd_csrs.logic_op), 64'd3);
        commit_valid = 1'b1; commit_ctx = 2'd2;
        tick(1);
        commit_valid = 1'b0;
        tick(1);
        chk("ctx2 logic_op new", 64'(rd_csrs.logic_op), 64'd6);

        // Simultaneous req/rsp leaves the count at 5.
        req_fire = 1'b1; req_ctx = 2'd0;
        tick(5);
        rsp_fire = 1'b1; rsp_ctx = 2'd0;
        tick(2);
        req_fire = 1'b0; rsp_fire = 1'b0;
        commit_valid = 1'b1; commit_ctx = 2'd0;
        tick(1);
        commit_valid = 1'b0;
        rsp_fire = 1'b1; rsp_ctx = 2'd0;
        tick(4);
        chk("ctx0 stall after 4", 64'(ctx_stall[0]), 64'd1);
        tick(1);
        rsp_fire = 1'b0;
        chk("ctx0 stall after 5", 64'(ctx_stall[0]), 64'd1);
        tick(1);
        chk("ctx0 done", 64'(commit_done), 64'b0001);
        chk("ctx0 stall clear", 64'(ctx_stall[0]), 64'd0);

        // Same-cycle write and commit; a second commit while pending is refused.
        csr_wr_valid = 1'b1; csr_wr_ctx = 2'd3; csr_wr_addr = 3'd6; csr_wr_data = 32'hFFFF_FFFA;
        commit_valid = 1'b1; commit_ctx = 2'd3;
        tick(1);
        csr_wr_valid = 1'b0;
        #1 chk("ctx3 commit_ready", 64'(commit_ready), 64'd0);
        tick(1);
        commit_valid = 1'b0;
        chk("ctx3 done", 64'(commit_done), 64'b1000);
        chk("ctx3 no re-commit", 64'(ctx_stall[3]), 64'd0);
        rd_ctx = 2'd3;
        #1 chk("ctx3 mode_rgb", 64'(rd_csrs.blend_mode_rgb), 64'd2);
        tick(1);

        // Reset during a pending commit with two fragments in flight.
        req_fire = 1'b1; req_ctx = 2'd1;
        tick(2);
        req_fire = 1'b0;
        commit_valid = 1'b1; commit_ctx = 2'd1;
        tick(1);
        commit_valid = 1'b0;
        chk("ctx1 pending", 64'(ctx_stall), 64'b0010);
        rd_ctx = 2'd1;
        #1 reset = 1'b1;
        #1 chk("rst stall", 64'(ctx_stall), 64'd0);
        chk("rst done", 64'(commit_done), 64'd0);
        chk("rst ctx1 const", 64'(rd_csrs.blend_const), 64'd0);
        tick(2);
        reset = 1'b0;
        tick(3);
        commit_valid = 1'b1; commit_ctx = 2'd1;
        tick(1);
        commit_valid = 1'b0;
        tick(1);
        chk("post-rst commit", 64'(commit_done), 64'b0010);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rop_csr_bank.md
# rop_csr_bank

Multi-context, double-buffered ROP state bank that succeeds the flat single-context blend/logic-op CSR record. Each of NUM_CTX contexts holds a shadow copy written by the CSR path and an active copy consumed by the ROP pipeline. A commit request copies shadow to active only once that context has no fragments in flight, so state changes are atomic with respect to in-flight work. The bank sits between the core CSR write path and the ROP blend/logic-op stages.

## Interface
- NUM_CTX, 4, number of independent state contexts (≥1)
- INFLIGHT_W, 8, width of the per-context in-flight fragment counter
- CTX_W, $clog2(NUM_CTX) (min 1), context index width (derived)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- csr_wr_valid  in  1  CSR write request
- csr_wr_ctx  in  CTX_W  target context
- csr_wr_addr  in  3  field select (map below)
- csr_wr_data  in  32  write data; the field takes its low bits
- csr_wr_ready  out  1  write accepted this cycle
- commit_valid  in  1  commit request
- commit_ctx  in  CTX_W  context to commit
- commit_ready  out  1  commit accepted this cycle
- commit_done  out  NUM_CTX  one-cycle pulse per context when its active copy is updated
- ctx_stall  out  NUM_CTX  context has a pending commit; upstream must not issue fragments for it
- req_fire  in  1  fragment enters ROP
- req_ctx  in  CTX_W  context of the entering fragment
- rsp_fire  in  1  fragment retires from ROP
- rsp_ctx  in  CTX_W  context of the retiring fragment
- rd_ctx  in  CTX_W  context whose active state is read
- rd_csrs  out  rop_csrs_ext_t  active state of rd_ctx (combinational)

## Operation
- Field map: 0 blend_src_rgb, 1 blend_dst_rgb, 2 blend_src_a, 3 blend_dst_a, 4 blend_const[31:0], 5 logic_op, 6 blend_mode_rgb, 7 blend_mode_a.
- Reset values, shadow and active: src factors ONE, dst factors ZERO, blend_const 0, logic_op COPY, modes ADD. Reset also clears all counters, all pending bits, commit_done and ctx_stall to 0, and sets both ready outputs to 1.
- Per-context FSM: IDLE → PENDING on commit accept. PENDING → IDLE when the registered counter equals 0: copy shadow to active and pulse commit_done[ctx].
- csr_wr_ready is 0 only when csr_wr_ctx is PENDING, which freezes the snapshot. commit_ready is 0 only when commit_ctx is already PENDING.
- A write and a commit to the same IDLE context in the same cycle are both accepted, and the write is included in the snapshot.
- Counter update: +1 on req_fire, −1 on rsp_fire. When both target the same context in one cycle, the counter is unchanged.
- Illegal conditions, flagged by assertions: req_fire to a context at its maximum count, rsp_fire to a context at 0, req_fire to a stalled context. No state change occurs in any of these cases.
- ctx_stall equals the PENDING bit.

## Timing
- Write accepted at edge T: the shadow field updates at T. It is visible in active only after a commit.
- Commit accepted at edge T with counter 0: the copy happens at edge T+1, commit_done is high during [T+1, T+2), and rd_csrs reflects the new state from T+1.
- Commit with N fragments in flight: the copy happens at the first edge after the counter's registered value reaches 0. Minimum latency is 1 cycle.
- ctx_stall rises at edge T (commit accept) and falls at the copy edge.
- A reset asserted mid-commit aborts the commit: no commit_done pulse, and the active copy returns to its defaults.

## Structure
- Extend package rop_types with:
  - rop_csrs_ext_t, which is the existing fields plus blend_mode_rgb/a (ROP_BLEND_MODE_BITS=3)
  - field-address localparams
  - reset-default constants
- Sub-module rop_ctx_slot holds one context's shadow/active registers, FSM and counter. It is instantiated NUM_CTX times.
- The top level does address/context decode and the rd_ctx read mux.

## Test plan
- Reset, then read ctx 0–3 → src factors ONE, dst factors ZERO, logic_op COPY, const 0, stall=0.
- Write blend_const=0xDEADBEEF to ctx 1, read ctx 1 → active const still 0; commit ctx 1 with counter 0 → commit_done[1] pulses one cycle later and rd_csrs.blend_const reads 0xDEADBEEF.
- 3 req_fire to ctx 2, then commit ctx 2 → ctx_stall[2]=1 and writes to ctx 2 are held (ready=0); after 3 rsp_fire → copy occurs, stall clears, and the held write is accepted.
- Simultaneous req_fire and rsp_fire to ctx 0 with counter 5 → counter remains 5; commit completes only after 5 further retirements.
- Write and commit to ctx 3 in the same cycle → the write appears in active; a second commit to ctx 3 while PENDING → commit_ready=0.
- Assert reset during a PENDING commit with counter 2 → all defaults restored, stall=0, no commit_done pulse.
